// File: rtl/depth_slicer.sv
// depth_slicer: tags each depth pixel with its threshold layer and counts pixels per layer per frame; DEPTH_SLICER_INVALID_EN makes depth 0 an uncounted invalid pixel
module depth_slicer #(
    parameter int p_depth_bit = 8,
    parameter int p_th_num    = 4,
    parameter int p_lbl_bit   = 3,
    parameter int p_dim_bit   = 10,
    parameter int p_cnt_bit   = 20
) (
    input  logic                                i_CLK,
    input  logic                                i_RST,
    input  logic [p_dim_bit-1:0]                i_WIDTH,
    input  logic [p_dim_bit-1:0]                i_HEIGHT,
    input  logic                                i_FRAME_START,
    input  logic                                i_TH_VALID,
    output logic                                o_TH_READY,
    input  logic [p_th_num*p_depth_bit-1:0]     i_HISTO_TH,
    input  logic                                i_DEPTH_VALID,
    output logic                                o_DEPTH_READY,
    input  logic [p_depth_bit-1:0]              i_DEPTH,
    output logic                                o_LABEL_VALID,
    input  logic                                i_LABEL_READY,
    output logic [p_lbl_bit-1:0]                o_LABEL,
    output logic [p_depth_bit-1:0]              o_DEPTH,
    output logic                                o_LAYER_CNT_VALID,
    output logic [(p_th_num+1)*p_cnt_bit-1:0]   o_LAYER_CNT,
`ifdef DEPTH_SLICER_INVALID_EN
    output logic [p_cnt_bit-1:0]                o_INVALID_CNT,
`endif
    output logic                                o_FRAME_DONE
);
    typedef enum logic [2:0] {IDLE, WAIT_TH, SLICE, DRAIN, DONE} state_t;
    state_t st, nxt;
    logic [p_dim_bit-1:0] w_r, h_r;
    logic [2*p_dim_bit-1:0] total, pix_idx;
    logic [p_th_num*p_depth_bit-1:0] th_r;
    logic [p_cnt_bit-1:0] cnt [p_th_num+1];
    logic [p_lbl_bit-1:0] lbl_n;
    logic th_hs, accept, last, out_free;

    assign total    = {{p_dim_bit{1'b0}}, w_r} * {{p_dim_bit{1'b0}}, h_r};
    assign th_hs    = o_TH_READY & i_TH_VALID;
    assign accept   = o_DEPTH_READY & i_DEPTH_VALID & ~i_FRAME_START;
    assign last     = pix_idx == total - (2*p_dim_bit)'(1);
    assign out_free = ~o_LABEL_VALID | i_LABEL_READY;

    always_comb begin
        lbl_n = '0;
        for (int k = 0; k < p_th_num; k++)
            lbl_n = lbl_n + p_lbl_bit'(i_DEPTH >= th_r[k*p_depth_bit +: p_depth_bit]);
`ifdef DEPTH_SLICER_INVALID_EN
        if (i_DEPTH == '0) lbl_n = '1;
`endif
    end

    always_ff @(posedge i_CLK) st <= i_RST ? IDLE : nxt;

    // a frame start from any state aborts whatever frame is in flight
    always_comb begin
        nxt = st;
        if (i_FRAME_START) nxt = WAIT_TH;
        else
            case (st)
                WAIT_TH: if (th_hs) nxt = total == '0 ? DONE : SLICE;
                SLICE:   if (accept && last) nxt = DRAIN;
                DRAIN:   if (out_free) nxt = DONE;
                default: nxt = IDLE;
            endcase
    end

    always_comb begin
        o_TH_READY    = st == WAIT_TH;
        o_DEPTH_READY = st == SLICE && out_free;
        o_FRAME_DONE  = st == DONE;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            w_r               <= '0;
            h_r               <= '0;
            th_r              <= '0;
            pix_idx           <= '0;
            o_LABEL_VALID     <= 1'b0;
            o_LABEL           <= '0;
            o_DEPTH           <= '0;
            o_LAYER_CNT_VALID <= 1'b0;
        end else begin
            if (i_FRAME_START) begin
                w_r               <= i_WIDTH;
                h_r               <= i_HEIGHT;
                pix_idx           <= '0;
                o_LAYER_CNT_VALID <= 1'b0;
            end else if (nxt == DONE) o_LAYER_CNT_VALID <= 1'b1;
            if (th_hs) th_r <= i_HISTO_TH;
            if (accept) pix_idx <= pix_idx + (2*p_dim_bit)'(1);
            if (i_FRAME_START) o_LABEL_VALID <= 1'b0;
            else if (accept) begin
                o_LABEL_VALID <= 1'b1;
                o_LABEL       <= lbl_n;
                o_DEPTH       <= i_DEPTH;
            end else if (i_LABEL_READY) o_LABEL_VALID <= 1'b0;
        end
    end

    // invalid labels are all-ones, above every layer index, so they never hit a layer counter
    always_ff @(posedge i_CLK)
        for (int j = 0; j <= p_th_num; j++)
            if (i_RST || i_FRAME_START) cnt[j] <= '0;
            else if (accept && int'(lbl_n) == j && cnt[j] != '1) cnt[j] <= cnt[j] + p_cnt_bit'(1);

`ifdef DEPTH_SLICER_INVALID_EN
    always_ff @(posedge i_CLK)
        if (i_RST || i_FRAME_START) o_INVALID_CNT <= '0;
        else if (accept && i_DEPTH == '0 && o_INVALID_CNT != '1) o_INVALID_CNT <= o_INVALID_CNT + p_cnt_bit'(1);
`endif

    for (genvar j = 0; j <= p_th_num; j++) begin : g_cnt
        assign o_LAYER_CNT[j*p_cnt_bit +: p_cnt_bit] = cnt[j];
    end
endmodule

// File: doc/depth_slicer.md
Name: depth_slicer

Overview:
- Downstream stage of the depth histogram block.
- Consumes the threshold vector that the histogram publishes on its XDS-out valid/ready handshake.
- Then re-streams the frame's depth pixels and tags each one with a layer label: the number of thresholds it meets or exceeds.
- Also accumulates a per-layer pixel count for the frame and reports it at frame end.

Parameters:
p_depth_bit, 8, depth pixel and threshold width
p_th_num, 4, number of thresholds; layers = p_th_num+1
p_lbl_bit, 3, label width; must satisfy 2**p_lbl_bit > p_th_num+1
p_dim_bit, 10, width/height field width
p_cnt_bit, 20, per-layer counter width

Ports:
i_CLK  in  1  clock
i_RST  in  1  synchronous reset, active-high
i_WIDTH  in  p_dim_bit  frame width; sampled on i_FRAME_START
i_HEIGHT  in  p_dim_bit  frame height; sampled on i_FRAME_START
i_FRAME_START  in  1  single-cycle frame start pulse
i_TH_VALID  in  1  threshold vector valid
o_TH_READY  out  1  threshold vector ready
i_HISTO_TH  in  p_th_num*p_depth_bit  thresholds; th[k] at bits [(k+1)*p_depth_bit-1 : k*p_depth_bit]
i_DEPTH_VALID  in  1  depth pixel valid
o_DEPTH_READY  out  1  depth pixel ready
i_DEPTH  in  p_depth_bit  depth pixel, raster order
o_LABEL_VALID  out  1  labelled pixel valid
i_LABEL_READY  in  1  labelled pixel ready
o_LABEL  out  p_lbl_bit  layer label
o_DEPTH  out  p_depth_bit  depth pixel, passed through alongside its label
o_LAYER_CNT_VALID  out  1  layer counts valid
o_LAYER_CNT  out  (p_th_num+1)*p_cnt_bit  per-layer counts; layer j at slice j
o_FRAME_DONE  out  1  single-cycle pulse at frame end

Behaviour:
- Interface: one clock, i_CLK. Reset is synchronous and active-high, i_RST.
- Reset: all outputs 0; state IDLE; counters and threshold registers cleared.
- FSM states: IDLE, WAIT_TH, SLICE, DRAIN, DONE.
- IDLE:
  - o_TH_READY=0, o_DEPTH_READY=0.
  - On i_FRAME_START: latch W and H, clear layer counters and pixel counter, drop o_LAYER_CNT_VALID, go to WAIT_TH.
- WAIT_TH:
  - o_TH_READY=1.
  - On i_TH_VALID&o_TH_READY: latch i_HISTO_TH.
  - If W*H==0, go to DONE; otherwise go to SLICE.
- SLICE:
  - o_DEPTH_READY = !o_LABEL_VALID | i_LABEL_READY (single output register, latency 1).
  - On each accepted pixel, next cycle: o_LABEL = count of k in [0,p_th_num) with depth >= th[k] (unsigned compare; threshold order is irrelevant); o_DEPTH = depth; o_LABEL_VALID=1; counter[label] increments.
  - o_LABEL_VALID clears when consumed and no new pixel is accepted in the same cycle.
  - Simultaneous consume and accept: the register reloads with no bubble.
  - When the accepted pixel's index equals W*H-1, go to DRAIN.
- DRAIN:
  - o_DEPTH_READY=0.
  - Once the output register is empty (or consumed this cycle), go to DONE.
- DONE:
  - o_FRAME_DONE=1 for one cycle; o_LAYER_CNT_VALID set; go to IDLE.
  - o_LAYER_CNT_VALID and o_LAYER_CNT then hold until the next i_FRAME_START.
- Counters: saturate at 2**p_cnt_bit-1 and never wrap.
- Pixel index: width 2*p_dim_bit.
- i_FRAME_START outside IDLE aborts the current frame:
  - output register is flushed, o_LABEL_VALID=0 next cycle;
  - counters are cleared and new W/H latched; go to WAIT_TH;
  - no o_FRAME_DONE pulse for the aborted frame.
- o_LABEL and o_DEPTH are held stable while o_LABEL_VALID=1 and i_LABEL_READY=0.
- Extra i_DEPTH_VALID outside SLICE: ignored (ready is low).
- i_RST mid-frame: immediate return to reset values next cycle.

Optional Feature:
- Macro: DEPTH_SLICER_INVALID_EN.
- When defined:
  - Pixel depth==0 is invalid: o_LABEL = all-ones.
  - Invalid pixels are not counted in any layer.
  - Extra output o_INVALID_CNT (p_cnt_bit, saturating) counts them; it follows the same valid/hold/clear rules as o_LAYER_CNT.
- When undefined:
  - Depth 0 is labelled normally (layer 0).
  - The o_INVALID_CNT port does not exist.

Test Plan:
- Labels and counts:
  - Stimulus: W=4, H=2, th={10,20,30,40} (th[0]=10), depths 0,9,10,25,40,255,30,19, ready held high.
  - Response: labels 0,0,1,2,4,4,3,1; counts L0..L4 = 2,2,1,1,2; one o_FRAME_DONE pulse.
- Backpressure:
  - Stimulus: same frame, i_LABEL_READY toggled 1,0,0,1 repeating.
  - Response: same 8 label/depth pairs in order, no loss or duplication; outputs stable while stalled; o_DEPTH_READY=0 whenever the register is full and not consumed.
- Abort:
  - Stimulus: i_FRAME_START after 3 pixels of a W=4, H=2 frame, then a full new frame with depth 5 everywhere.
  - Response: no FRAME_DONE for the first frame; final counts L0=8, all others 0.
- Zero-size frame:
  - Stimulus: H=0, thresholds accepted.
  - Response: o_DEPTH_READY never asserted; FRAME_DONE one cycle after TH handshake; all counts 0.
- Saturation:
  - Stimulus: p_cnt_bit=3, W=10, H=1, all depths 5.
  - Response: L0=7, others 0.
- Invalid pixels (DEPTH_SLICER_INVALID_EN defined):
  - Stimulus: first test vector.
  - Response: pixel 0 labelled 7; o_INVALID_CNT=1; L0=1, other counts unchanged.
